utx_seq: RTL

Transmit sequencer sitting directly upstream of `uart_tx` in the tester. It buffers 6-bit result words from the tester core in a FIFO. It presents each word to `uart_tx` on `out_mem` and starts the transfer with a one-cycle `out_utx_st` strobe. It waits for the `uart_tx` done pulse before issuing the next word, so the core can burst results without tracking serial-line pacing.

---
 rtl/tester_pkg.sv | 17 +
 rtl/utx_fifo.sv | 51 +++++
 rtl/utx_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/tester_pkg.sv
// Shared tester definitions: result word width and the transmit sequencer states.
// UTX_SEQ_EOL_EN adds the LOAD_EOL state used for the optional terminator word.
package tester_pkg;

  localparam int UTX_WORD_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef UTX_SEQ_EOL_EN
    LOAD_EOL,
`endif
    START,
    WAIT
  } utx_seq_state_t;

endpackage

// File: rtl/utx_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers; flush overrides push and pop.
module utx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 6,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] level
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; empty/full come from the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/utx_seq.sv
// Transmit sequencer feeding uart_tx one buffered word per start/done handshake.
// Optional terminator word after each drained burst when UTX_SEQ_EOL_EN is defined.
module utx_seq
  import tester_pkg::*;
#(
  parameter int                    DEPTH    = 16,
  parameter logic [UTX_WORD_W-1:0] EOL_CODE = 6'h0A,
  localparam int                   LW       = $clog2(DEPTH) + 1
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic [UTX_WORD_W-1:0] in_wr_data,
  input  logic                  in_wr_vld,
  output logic                  out_wr_rdy,
  input  logic                  in_flush,
  output logic [LW-1:0]         out_level,
  output logic                  out_drop,
  output logic [UTX_WORD_W-1:0] out_mem,
  output logic                  out_utx_st,
  input  logic                  in_utx_bs,
  input  logic                  in_utx_rd
);

  utx_seq_state_t        state;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [UTX_WORD_W-1:0] fifo_head;
  logic                  unused_in;

  assign out_wr_rdy = !fifo_full;
  assign fifo_pop   = (state == LOAD);

  utx_fifo #(
    .DEPTH (DEPTH),
    .W     (UTX_WORD_W)
  ) u_fifo (
    .clk     (in_clk),
    .rst_n   (in_rst),
    .push    (in_wr_vld),
    .pop     (fifo_pop),
    .flush   (in_flush),
    .wr_data (in_wr_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (out_level)
  );

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      out_drop <= 1'b0;
    end else if (in_flush) begin
      out_drop <= 1'b0;
    end else if (in_wr_vld && fifo_full) begin
      out_drop <= 1'b1;
    end
  end

  // Busy is not consulted: a start issued while uart_tx is busy is simply
  // covered by waiting for that transfer's done pulse.
`ifdef UTX_SEQ_EOL_EN
  logic eol_pending;

  assign unused_in = in_utx_bs;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      eol_pending <= 1'b0;
    end else if (state == LOAD) begin
      eol_pending <= 1'b1;
    end else if (state == LOAD_EOL) begin
      eol_pending <= 1'b0;
    end
  end
`else
  assign unused_in = in_utx_bs ^ (^EOL_CODE);
`endif

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state      <= IDLE;
      out_mem    <= '0;
      out_utx_st <= 1'b0;
    end else begin
      out_utx_st <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= LOAD;
`ifdef UTX_SEQ_EOL_EN
          end else if (eol_pending) begin
            state <= LOAD_EOL;
`endif
          end
        end
        LOAD: begin
          out_mem    <= fifo_head;
          out_utx_st <= 1'b1;
          state      <= START;
        end
`ifdef UTX_SEQ_EOL_EN
        LOAD_EOL: begin
          out_mem    <= EOL_CODE;
          out_utx_st <= 1'b1;
          state      <= START;
        end
`endif
        START: state <= WAIT;
        WAIT: begin
          if (in_utx_rd) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
